sipo_rx: RTL
============

Name: sipo_rx

Overview:
- Serial-to-parallel receive stage; sits directly downstream of the 4-bit parallel-load shift-out stage and consumes its MSB-first serial stream.
- Frames W bits starting on a start strobe and presents each completed word on a one-deep holding register with valid/ready handshake.
- Flags overrun (word lost while holding register is occupied) and aborted frames (restart mid-frame) as sticky status.

Parameters:
- W, 4, word width in bits; legal range is 2 or more. The default matches the upstream stage's 4-bit word.

Ports:
- clk  in  1  Rising-edge clock.
- rst  in  1  Asynchronous, active-low reset. rst=0 resets immediately, independent of clk.
- sin  in  1  Serial data, MSB first, one bit per clk.
- start  in  1  Frame strobe; high in the same cycle as the MSB on sin.
- dout  out  W  Received word, MSB = first bit received.
- dout_vld  out  1  dout holds an unconsumed word.
- dout_rdy  in  1  Consumer accepts dout on a clk edge where dout_vld=1 and dout_rdy=1.
- busy  out  1  Frame in progress (state SHIFT).
- ovf  out  1  Sticky overrun flag.
- abrt  out  1  Sticky aborted-frame flag.
- clr  in  1  Synchronous clear of ovf and abrt.

Behaviour:
- Reset (rst=0): state=IDLE, shift register=0, bit count=0, dout=0, dout_vld=0, busy=0, ovf=0, abrt=0.
- States:
  - IDLE: waiting for start.
  - SHIFT: collecting bits 2..W.
- IDLE:
  - start=1 at edge: sample sin into the shift register LSB, set count=1, go to SHIFT.
  - start=0: sin is ignored and there is no state change.
- SHIFT, each edge:
  - Shift left, insert sin at the LSB, count+1.
  - When the bit being sampled is the W-th (count==W-1 before the edge): the word is complete, go to IDLE, count=0.
- Latency:
  - start sampled at edge k; last bit sampled at edge k+W-1.
  - Word is on dout with dout_vld=1 after edge k+W-1, provided the word is accepted into the holding register.
- Holding register transfer on word completion:
  - Accept when dout_vld=0, or when dout_vld=1 and dout_rdy=1 at the same edge (drain and refill together). dout takes the new word and dout_vld stays or goes to 1.
  - Otherwise the word is dropped, dout and dout_vld are unchanged, and ovf is set to 1.
- Handshake:
  - dout_vld falls after an edge with dout_vld and dout_rdy both high, unless a refill occurs at that edge.
  - dout is stable while dout_vld=1 and dout_rdy=0.
- Back-to-back frames: start is accepted in the cycle immediately after the last bit, giving a gap-free stream of one word every W cycles. With dout_rdy held at 1, there is no overrun.
- start=1 while in SHIFT (including the W-th bit cycle):
  - The current partial frame is discarded and no word is produced.
  - abrt is set to 1.
  - sin in that cycle is taken as the MSB of the new frame: count=1, state stays SHIFT.
- Sticky flags:
  - ovf and abrt stay at 1 until clr=1 or reset.
  - If clr=1 and a new set event occur at the same edge, the set wins and the flag stays 1.
- busy = (state==SHIFT), driven from a register.
- Reset mid-frame or mid-handshake: everything returns to reset values immediately. The partial frame and the held word are lost, and there is no spurious dout_vld after rst is released.
- Arithmetic: bit count width is clog2(W), with no wrap beyond W-1.

Test Plan:
- Reset, then start with sin=1,0,1,1 over 4 cycles, dout_rdy=1 -> after the 4th edge dout=4'hB, dout_vld=1 for one cycle; busy=1 for 3 cycles.
- Back-to-back 4'hB then 4'h6 with start every 4th cycle, dout_rdy=1 -> dout_vld pulses 4 cycles apart, values B then 6, ovf=0.
- dout_rdy=0, send 4'hA then 4'h5 -> dout holds A, dout_vld=1, ovf=1 after the 2nd word completes; raise dout_rdy -> A consumed, dout_vld=0.
- Start, 2 bits (1,1), then start again with 0,0,1,1 -> abrt=1, single word dout=4'h3, no word for the aborted frame; clr=1 -> abrt=0.
- Word waiting with dout_rdy=0; assert dout_rdy=1 on the edge the next word (4'hC) completes -> old word consumed, dout=C, dout_vld stays 1, ovf=0.
- Assert rst=0 asynchronously mid-frame (between edges) with dout_vld=1 -> outputs clear immediately; release, send 4'h9 -> dout=9 with no stale bits.

Source files
------------

// File: rtl/sipo_rx.sv
// rtl/sipo_rx.sv - MSB-first serial-to-parallel receiver with one-deep output holding register
module sipo_rx #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         start,
    output logic [W-1:0] dout,
    output logic         dout_vld,
    input  logic         dout_rdy,
    output logic         busy,
    output logic         ovf,
    output logic         abrt,
    input  logic         clr
);
    localparam int CW = $clog2(W);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   sreg_q, sreg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   dout_q, dout_d;
    logic           vld_q, vld_d;
    logic           busy_q, busy_d;
    logic           ovf_q, ovf_d;
    logic           abrt_q, abrt_d;
    logic           ovf_set, abrt_set;
    logic [W-1:0]   word;
    logic [W-1:0]   first_bit;

    assign word      = {sreg_q[W-2:0], sin};
    assign first_bit = {{(W-1){1'b0}}, sin};

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        vld_d    = vld_q;
        ovf_set  = 1'b0;
        abrt_set = 1'b0;

        if (vld_q && dout_rdy) begin
            vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    sreg_d  = first_bit;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (start) begin
                    // Restart wins even on the final bit: the partial word is never delivered.
                    abrt_set = 1'b1;
                    sreg_d   = first_bit;
                    cnt_d    = CW'(1);
                end else if (cnt_q == CW'(W - 1)) begin
                    sreg_d  = word;
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!vld_q || dout_rdy) begin
                        dout_d = word;
                        vld_d  = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end else begin
                    sreg_d = word;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        // A set event at the same edge as clr keeps the flag high.
        ovf_d  = ovf_set  | (ovf_q  & ~clr);
        abrt_d = abrt_set | (abrt_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            abrt_q  <= abrt_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q;
    assign busy     = busy_q;
    assign ovf      = ovf_q;
    assign abrt     = abrt_q;
endmodule
